mod_counter: RTL and testbench

MOD_COUNTER -- requirements
Module: mod_counter

---
 rtl/mod_counter_pkg.sv | 15 +
 rtl/counter_prescaler.sv | 39 +++
 rtl/mod_counter.sv | 111 +++++++++++
 tb/tb_mod_counter.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mod_counter_pkg.sv
// Shared types for the modulo/saturating counter: direction and boundary policy.
// No logic lives here; the other files import these types.
package mod_counter_pkg;

  typedef enum logic {
    UP   = 1'b0,
    DOWN = 1'b1
  } count_dir_e;

  typedef enum logic {
    WRAP     = 1'b0,
    SATURATE = 1'b1
  } wrap_mode_e;

endpackage

// File: rtl/counter_prescaler.sv
// Tick divisor: one tick_o per div_i+1 enabled cycles; tick is combinational from the phase register.
// No backpressure; en_i low freezes the phase, clr_i returns it to 0 and suppresses the tick.
module counter_prescaler #(
  parameter int PRESC_W = 8
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               en_i,
  input  logic               clr_i,
  input  logic [PRESC_W-1:0] div_i,
  output logic               tick_o
);

  logic [PRESC_W-1:0] cnt_q;
  logic [PRESC_W-1:0] cnt_d;
  logic               at_div;

  // >= rather than == so a divisor lowered below the current phase ticks at once
  assign at_div = (cnt_q >= div_i);

  always_comb begin
    tick_o = en_i && !clr_i && at_div;
    cnt_d  = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = at_div ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/mod_counter.sv
// Prescaled up/down counter over 0..limit_i with wrap or saturate boundaries; count_o/tc_o one clock after tick/load/clear.
// No backpressure; clear beats load beats tick, and clear/load act regardless of en_i.
module mod_counter
  import mod_counter_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int STEP_W  = 4,
  parameter int PRESC_W = 8
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               en_i,
  input  count_dir_e         dir_i,
  input  wrap_mode_e         mode_i,
  input  logic [STEP_W-1:0]  step_i,
  input  logic [WIDTH-1:0]   limit_i,
  input  logic [PRESC_W-1:0] presc_i,
  input  logic               clear_i,
  input  logic               load_i,
  input  logic [WIDTH-1:0]   load_val_i,
  output logic [WIDTH-1:0]   count_o,
  output logic               tc_o,
  output logic               zero_o
);

  localparam int XW = WIDTH + 1;

  logic [WIDTH-1:0] count_q, count_d;
  logic             tc_q, tc_d;
  logic             tick;
  logic             presc_clr;

  logic [XW-1:0]    cnt_x, lim_x, step_x, s_x, sum_x;
  logic [WIDTH-1:0] tick_cnt;
  logic             tick_tc;

  assign presc_clr = clear_i | load_i;

  counter_prescaler #(
    .PRESC_W (PRESC_W)
  ) u_presc (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .en_i   (en_i),
    .clr_i  (presc_clr),
    .div_i  (presc_i),
    .tick_o (tick)
  );

  // Boundary arithmetic in WIDTH+1 bits so count+step and count+limit+1 never lose a carry
  always_comb begin
    cnt_x    = {1'b0, count_q};
    lim_x    = {1'b0, limit_i};
    step_x   = XW'(step_i);
    s_x      = (step_x > lim_x) ? lim_x : step_x;
    sum_x    = cnt_x + s_x;
    tick_cnt = count_q;
    tick_tc  = 1'b0;

    if (limit_i == '0) begin
      // Single-value range: any nonzero step, or a stale nonzero count, is a boundary event
      tick_cnt = '0;
      tick_tc  = (step_i != '0) || (count_q != '0);
    end else if (cnt_x > lim_x) begin
      tick_tc  = 1'b1;
      tick_cnt = (dir_i == UP) ? '0 : limit_i;
    end else if (dir_i == UP) begin
      if (sum_x <= lim_x) begin
        tick_cnt = WIDTH'(sum_x);
      end else begin
        tick_tc  = 1'b1;
        tick_cnt = (mode_i == WRAP) ? WIDTH'(sum_x - lim_x - XW'(1)) : limit_i;
      end
    end else begin
      if (cnt_x >= s_x) begin
        tick_cnt = WIDTH'(cnt_x - s_x);
      end else begin
        tick_tc  = 1'b1;
        tick_cnt = (mode_i == WRAP) ? WIDTH'(cnt_x + lim_x + XW'(1) - s_x) : '0;
      end
    end
  end

  always_comb begin
    count_d = count_q;
    tc_d    = 1'b0;
    if (clear_i) begin
      count_d = '0;
    end else if (load_i) begin
      count_d = (load_val_i > limit_i) ? limit_i : load_val_i;
    end else if (tick) begin
      count_d = tick_cnt;
      tc_d    = tick_tc;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count_q <= '0;
      tc_q    <= 1'b0;
    end else begin
      count_q <= count_d;
      tc_q    <= tc_d;
    end
  end

  assign count_o = count_q;
  assign tc_o    = tc_q;
  assign zero_o  = (count_q == '0);

endmodule

// File: tb/tb_mod_counter.sv
// Directed plus randomized checks of mod_counter against an arithmetic reference model.
module tb_mod_counter;
  import mod_counter_pkg::*;

  localparam int WIDTH   = 8;
  localparam int STEP_W  = 4;
  localparam int PRESC_W = 8;

  logic               clk_i = 1'b0;
  logic               rst_i;
  logic               en_i;
  count_dir_e         dir_i;
  wrap_mode_e         mode_i;
  logic [STEP_W-1:0]  step_i;
  logic [WIDTH-1:0]   limit_i;
  logic [PRESC_W-1:0] presc_i;
  logic               clear_i;
  logic               load_i;
  logic [WIDTH-1:0]   load_val_i;
  logic [WIDTH-1:0]   count_o;
  logic               tc_o;
  logic               zero_o;

  int n_cmp  = 0;
  int n_fail = 0;

  int m_count = 0;
  int m_presc = 0;
  int m_tc    = 0;

  always #5 clk_i = ~clk_i;

  mod_counter #(
    .WIDTH   (WIDTH),
    .STEP_W  (STEP_W),
    .PRESC_W (PRESC_W)
  ) dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .en_i       (en_i),
    .dir_i      (dir_i),
    .mode_i     (mode_i),
    .step_i     (step_i),
    .limit_i    (limit_i),
    .presc_i    (presc_i),
    .clear_i    (clear_i),
    .load_i     (load_i),
    .load_val_i (load_val_i),
    .count_o    (count_o),
    .tc_o       (tc_o),
    .zero_o     (zero_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference: counter lives on the ring/segment 0..lim, moved by s = min(step, lim)
  task automatic model_step();
    int lim, cnt, s, t;
    bit tk;
    lim = int'(limit_i);
    cnt = m_count;
    tk  = 0;
    if (rst_i) begin
      m_count = 0; m_presc = 0; m_tc = 0;
    end else if (clear_i) begin
      m_count = 0; m_presc = 0; m_tc = 0;
    end else if (load_i) begin
      m_count = (int'(load_val_i) < lim) ? int'(load_val_i) : lim;
      m_presc = 0; m_tc = 0;
    end else begin
      m_tc = 0;
      if (en_i) begin
        if (m_presc >= int'(presc_i)) begin
          tk = 1; m_presc = 0;
        end else begin
          m_presc++;
        end
      end
      if (tk) begin
        if (lim == 0) begin
          m_count = 0;
          m_tc    = (step_i != 0 || cnt != 0) ? 1 : 0;
        end else if (cnt > lim) begin
          m_count = (dir_i == UP) ? 0 : lim;
          m_tc    = 1;
        end else begin
          s = (int'(step_i) < lim) ? int'(step_i) : lim;
          if (dir_i == UP) begin
            t = cnt + s;
            if (t > lim) begin
              m_tc    = 1;
              m_count = (mode_i == WRAP) ? t % (lim + 1) : lim;
            end else begin
              m_count = t;
            end
          end else begin
            t = cnt - s;
            if (t < 0) begin
              m_tc    = 1;
              m_count = (mode_i == WRAP) ? t + lim + 1 : 0;
            end else begin
              m_count = t;
            end
          end
        end
      end
    end
  endtask

  task automatic cyc(input string tag);
    model_step();
    @(posedge clk_i);
    #1;
    chk({tag, ".count"}, 32'(count_o), 32'(m_count));
    chk({tag, ".tc"},    32'(tc_o),    32'(m_tc));
    chk({tag, ".zero"},  32'(zero_o),  32'(m_count == 0));
  endtask

  initial begin
    int exp_sd[4];
    int tc_sd[4];
    exp_sd = '{4, 1, 0, 0};
    tc_sd  = '{0, 0, 1, 1};

    rst_i = 1'b1; en_i = 1'b0; dir_i = UP; mode_i = WRAP; step_i = 1;
    limit_i = 9; presc_i = 0; clear_i = 1'b0; load_i = 1'b0; load_val_i = '0;
    #3;
    chk("por.count", 32'(count_o), 0);
    chk("por.tc",    32'(tc_o),    0);
    chk("por.zero",  32'(zero_o),  1);
    cyc("por_hold");
    rst_i = 1'b0;

    // Wrap up over 0..9, tc on the 10th tick only
    en_i = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      cyc("wrap_up");
      chk("wrap_up.k_count", 32'(count_o), (i == 10) ? 0 : i);
      chk("wrap_up.k_tc",    32'(tc_o),    (i == 10) ? 1 : 0);
    end
    step_i = 4; load_i = 1'b1; load_val_i = 8;
    cyc("load8");
    load_i = 1'b0;
    cyc("wrap_step4");
    chk("wrap_step4.k_count", 32'(count_o), 2);
    chk("wrap_step4.k_tc",    32'(tc_o),    1);

    // Saturating down, tc repeats while pinned at 0
    mode_i = SATURATE; dir_i = DOWN; limit_i = 99; step_i = 3;
    load_i = 1'b1; load_val_i = 7;
    cyc("sat_load7");
    load_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cyc("sat_dn");
      chk("sat_dn.k_count", 32'(count_o), exp_sd[i]);
      chk("sat_dn.k_tc",    32'(tc_o),    tc_sd[i]);
    end
    cyc("sat_dn_more");

    // Prescaler divide-by-4 and phase hold while disabled
    mode_i = WRAP; dir_i = UP; step_i = 1; presc_i = 3;
    clear_i = 1'b1;
    cyc("presc_clr");
    clear_i = 1'b0;
    for (int i = 0; i < 16; i++) cyc("presc_run");
    chk("presc_run.k_count", 32'(count_o), 4);
    en_i = 1'b1; cyc("presc_ph1"); cyc("presc_ph2");
    en_i = 1'b0;
    for (int i = 0; i < 3; i++) cyc("presc_hold");
    en_i = 1'b1;
    cyc("presc_resume1");
    chk("presc_resume1.k_count", 32'(count_o), 4);
    cyc("presc_resume2");
    chk("presc_resume2.k_count", 32'(count_o), 5);
    presc_i = 0;

    // Priority and load clamping
    clear_i = 1'b1; load_i = 1'b1; load_val_i = 50;
    cyc("clr_over_ld");
    chk("clr_over_ld.k_count", 32'(count_o), 0);
    clear_i = 1'b0; load_val_i = 200;
    cyc("ld_clamp");
    chk("ld_clamp.k_count", 32'(count_o), 99);
    en_i = 1'b0; load_val_i = 30;
    cyc("ld_no_en");
    chk("ld_no_en.k_count", 32'(count_o), 30);
    load_i = 1'b0; en_i = 1'b1;

    // Limit lowered below the live count
    limit_i = 99; load_i = 1'b1; load_val_i = 50;
    cyc("live_ld");
    load_i = 1'b0; limit_i = 20; dir_i = UP;
    cyc("live_up");
    chk("live_up.k_count", 32'(count_o), 0);
    chk("live_up.k_tc",    32'(tc_o),    1);
    limit_i = 99; load_i = 1'b1;
    cyc("live_ld2");
    load_i = 1'b0; limit_i = 20; dir_i = DOWN; mode_i = SATURATE;
    cyc("live_dn");
    chk("live_dn.k_count", 32'(count_o), 20);
    chk("live_dn.k_tc",    32'(tc_o),    1);

    // Zero-width range
    limit_i = 0; step_i = 5; mode_i = WRAP; dir_i = UP;
    for (int i = 0; i < 3; i++) cyc("lim0_step");
    step_i = 0;
    cyc("lim0_nostep");

    // Async reset mid-operation restarts the prescaler phase
    limit_i = 99; step_i = 1; presc_i = 3; clear_i = 1'b1;
    cyc("mid_clr");
    clear_i = 1'b0; load_i = 1'b1; load_val_i = 5;
    cyc("mid_ld5");
    load_i = 1'b0;
    cyc("mid_run1"); cyc("mid_run2");
    #2 rst_i = 1'b1;
    #1;
    m_count = 0; m_presc = 0; m_tc = 0;
    chk("async_rst.count", 32'(count_o), 0);
    chk("async_rst.tc",    32'(tc_o),    0);
    chk("async_rst.zero",  32'(zero_o),  1);
    cyc("rst_held");
    rst_i = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      cyc("post_rst");
      chk("post_rst.k_count", 32'(count_o), (i == 4) ? 1 : 0);
    end

    // Randomized traffic against the model
    for (int i = 0; i < 600; i++) begin
      clear_i    = ($urandom_range(0, 99) < 3);
      load_i     = ($urandom_range(0, 99) < 5);
      load_val_i = WIDTH'($urandom_range(0, 255));
      en_i       = ($urandom_range(0, 99) < 80);
      dir_i      = count_dir_e'($urandom_range(0, 1));
      mode_i     = wrap_mode_e'($urandom_range(0, 1));
      step_i     = STEP_W'($urandom_range(0, 15));
      if ($urandom_range(0, 99) < 5) begin
        case ($urandom_range(0, 3))
          0:       limit_i = 0;
          1:       limit_i = WIDTH'($urandom_range(1, 12));
          2:       limit_i = 255;
          default: limit_i = WIDTH'($urandom_range(0, 255));
        endcase
      end
      if ($urandom_range(0, 99) < 4) presc_i = PRESC_W'($urandom_range(0, 3));
      cyc("rnd");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
